// File: rtl/rv_pkg.sv
// Shared types for the RV32I/RV64I decode stage: ALU codes, major opcodes,
// writeback selects and the packed control bundle carried down the pipe.
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101,
        ALU_NOP  = 4'b1111
    } t_aluCodes;

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_OPIMM  = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_OP     = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011
    } t_opcodes;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } t_wbSel;

    typedef struct packed {
        logic      regWrite;
        logic      memWrite;
        logic      memRead;
        logic      branch;
        logic      jump;
        logic      srcAPc;
        logic      srcBImm;
        t_wbSel    wbSel;
        t_aluCodes aluCode;
        logic      illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
    } t_ctrl;

    localparam t_ctrl CTRL_RESET = '{
        regWrite: 1'b0, memWrite: 1'b0, memRead: 1'b0, branch: 1'b0,
        jump: 1'b0, srcAPc: 1'b0, srcBImm: 1'b0, wbSel: WB_ALU,
        aluCode: ALU_NOP, illegal: 1'b0,
        rd: 5'd0, rs1: 5'd0, rs2: 5'd0, funct3: 3'd0
    };

    // ALU code layout mirrors {instr[30], funct3} so OP/OPIMM map directly.
    function automatic t_aluCodes aluFromFunct(input logic bit30, input logic [2:0] funct3);
        return t_aluCodes'({bit30, funct3});
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational RV32I/RV64I decoder: instruction word to control
// bundle plus sign-extended immediate. Illegal encodings yield a NOP bundle.
module instr_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output t_ctrl           o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immJ;
    logic [31:0] w_immU;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_shiftOk;
    logic        w_isShift;
    t_ctrl       w_ctrl;
    logic [31:0] w_imm32;
    logic        w_illegal;

    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    assign w_immI = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_immS = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_immB = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_immJ = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_immU = {i_instr[31:12], 12'b0};

    // On RV64 instr[25] is shamt[5], so only the upper six funct bits qualify.
    assign w_isShift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_shiftOk = (XLEN == 64)
                     ? ((i_instr[31:26] == 6'b000000) || (i_instr[31:26] == 6'b010000))
                     : ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));

    always_comb begin
        w_ctrl        = CTRL_RESET;
        w_ctrl.rd     = i_instr[11:7];
        w_ctrl.rs1    = i_instr[19:15];
        w_ctrl.rs2    = i_instr[24:20];
        w_ctrl.funct3 = w_funct3;
        w_imm32       = '0;
        w_illegal     = 1'b0;

        if (i_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (t_opcodes'(i_instr[6:2]))
                OP_LUI: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.wbSel    = WB_IMM;
                    w_imm32         = w_immU;
                end
                OP_AUIPC: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.srcAPc   = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.aluCode  = ALU_ADD;
                    w_imm32         = w_immU;
                end
                OP_JAL: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.jump     = 1'b1;
                    w_ctrl.srcAPc   = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.wbSel    = WB_PC4;
                    w_ctrl.aluCode  = ALU_ADD;
                    w_imm32         = w_immJ;
                end
                OP_JALR: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.jump     = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.wbSel    = WB_PC4;
                    w_ctrl.aluCode  = ALU_ADD;
                    w_imm32         = w_immI;
                    w_illegal       = (w_funct3 != 3'b000);
                end
                OP_BRANCH: begin
                    w_ctrl.branch  = 1'b1;
                    w_ctrl.aluCode = ALU_SUB;
                    w_imm32        = w_immB;
                    w_illegal      = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                end
                OP_LOAD: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.memRead  = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.wbSel    = WB_MEM;
                    w_ctrl.aluCode  = ALU_ADD;
                    w_imm32         = w_immI;
                end
                OP_STORE: begin
                    w_ctrl.memWrite = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.aluCode  = ALU_ADD;
                    w_imm32         = w_immS;
                end
                OP_OPIMM: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.srcBImm  = 1'b1;
                    w_ctrl.aluCode  = aluFromFunct(i_instr[30] && (w_funct3 == 3'b101), w_funct3);
                    w_imm32         = w_immI;
                    w_illegal       = w_isShift && !w_shiftOk;
                end
                OP_OP: begin
                    w_ctrl.regWrite = 1'b1;
                    w_ctrl.aluCode  = aluFromFunct(i_instr[30], w_funct3);
                    w_illegal       = !((w_funct7 == 7'b0000000) ||
                                        ((w_funct7 == 7'b0100000) &&
                                         ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Register indices and funct3 still pass through for illegal words.
    always_comb begin
        o_ctrl = w_ctrl;
        o_imm  = XLEN'($signed(w_imm32));
        if (w_illegal) begin
            o_ctrl         = CTRL_RESET;
            o_ctrl.rd      = i_instr[11:7];
            o_ctrl.rs1     = i_instr[19:15];
            o_ctrl.rs2     = i_instr[24:20];
            o_ctrl.funct3  = w_funct3;
            o_ctrl.illegal = 1'b1;
            o_imm          = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage with valid/ready on both sides and an
// optional skid entry so in_ready is a flop rather than a path from out_ready.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_aluCode,
    output logic [XLEN-1:0] out_imm,
    output logic            out_regWrite,
    output logic            out_memWrite,
    output logic            out_memRead,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_srcAPc,
    output logic            out_srcBImm,
    output logic [1:0]      out_wbSel,
    output logic            out_illegal
);

    t_ctrl           w_decCtrl;
    logic [XLEN-1:0] w_decImm;
    logic            w_outFree;
    logic            w_inFire;

    logic            r_outValid;
    t_ctrl           r_outCtrl;
    logic [XLEN-1:0] r_outImm;
    logic [XLEN-1:0] r_outPc;
    logic            r_skidValid;
    t_ctrl           r_skidCtrl;
    logic [XLEN-1:0] r_skidImm;
    logic [XLEN-1:0] r_skidPc;
    logic            r_inReady;

    instr_decode #(
        .XLEN (XLEN)
    ) u_instrDecode (
        .i_instr (in_instr),
        .o_ctrl  (w_decCtrl),
        .o_imm   (w_decImm)
    );

    // Without the skid entry a stalled output blocks intake directly.
    assign w_outFree = !r_outValid || out_ready;
    assign in_ready  = (SKID != 0) ? r_inReady : w_outFree;
    assign w_inFire  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_outCtrl   <= CTRL_RESET;
            r_outImm    <= '0;
            r_outPc     <= '0;
            r_skidValid <= 1'b0;
            r_skidCtrl  <= CTRL_RESET;
            r_skidImm   <= '0;
            r_skidPc    <= '0;
            r_inReady   <= 1'b1;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else if (w_outFree) begin
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_outCtrl   <= r_skidCtrl;
                r_outImm    <= r_skidImm;
                r_outPc     <= r_skidPc;
                r_skidValid <= 1'b0;
                r_inReady   <= 1'b1;
            end else if (w_inFire) begin
                r_outValid <= 1'b1;
                r_outCtrl  <= w_decCtrl;
                r_outImm   <= w_decImm;
                r_outPc    <= in_pc;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_inFire) begin
            r_skidValid <= 1'b1;
            r_skidCtrl  <= w_decCtrl;
            r_skidImm   <= w_decImm;
            r_skidPc    <= in_pc;
            r_inReady   <= 1'b0;
        end
    end

    assign out_valid    = r_outValid;
    assign out_pc       = r_outPc;
    assign out_imm      = r_outImm;
    assign out_rd       = r_outCtrl.rd;
    assign out_rs1      = r_outCtrl.rs1;
    assign out_rs2      = r_outCtrl.rs2;
    assign out_funct3   = r_outCtrl.funct3;
    assign out_aluCode  = r_outCtrl.aluCode;
    assign out_regWrite = r_outCtrl.regWrite;
    assign out_memWrite = r_outCtrl.memWrite;
    assign out_memRead  = r_outCtrl.memRead;
    assign out_branch   = r_outCtrl.branch;
    assign out_jump     = r_outCtrl.jump;
    assign out_srcAPc   = r_outCtrl.srcAPc;
    assign out_srcBImm  = r_outCtrl.srcBImm;
    assign out_wbSel    = r_outCtrl.wbSel;
    assign out_illegal  = r_outCtrl.illegal;

endmodule
